// File: rtl/icache_pkg.sv
// icache_pkg: shared state type, NOP constant and address-split width helpers for the instruction cache
package icache_pkg;
    typedef enum logic {IDLE, REFILL} state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction
    function automatic int tag_bits(input int sets, input int words);
        return 30 - $clog2(sets) - $clog2(words);
    endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: tag/valid/data arrays with one write port and one asynchronous read port
module icache_line_store import icache_pkg::*; #(
    parameter int SETS  = 16,
    parameter int WORDS = 4,
    parameter int IW    = idx_bits(SETS),
    parameter int OW    = off_bits(WORDS),
    parameter int TW    = tag_bits(SETS, WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [OW-1:0] i_wr_word,
    input  logic [31:0]   i_wr_data,
    input  logic          i_set_tag,
    input  logic [TW-1:0] i_tag,
    input  logic          i_clear_all,
    input  logic [IW-1:0] i_rd_idx,
    input  logic [OW-1:0] i_rd_word,
    output logic          o_rd_valid,
    output logic [TW-1:0] o_rd_tag,
    output logic [31:0]   o_rd_data
);
    logic [SETS-1:0] r_valid;
    logic [TW-1:0]   r_tag  [SETS];
    logic [31:0]     r_data [SETS][WORDS];

    // Data and tags carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_data[i_wr_idx][i_wr_word] <= i_wr_data;
        if (i_set_tag) r_tag[i_wr_idx] <= i_tag;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear_all) r_valid <= '0;
        else if (i_set_tag) r_valid[i_wr_idx] <= 1'b1;
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx][i_rd_word];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with zero-latency hits and stall-and-refill on miss
module icache_direct import icache_pkg::*; #(
    parameter int          SETS           = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INSTR      = icache_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        invalidate,
    output logic [31:0] instr,
    output logic        hit,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);
    localparam int OW = off_bits(WORDS_PER_LINE);
    localparam int IW = idx_bits(SETS);
    localparam int TW = tag_bits(SETS, WORDS_PER_LINE);

    state_t           r_state, w_next;
    logic [OW-1:0]    r_cnt;
    logic [IW+TW-1:0] r_base;
    logic [OW-1:0]    w_word;
    logic [IW-1:0]    w_idx;
    logic [TW-1:0]    w_tag, w_rd_tag;
    logic [31:0]      w_rd_data;
    logic             w_rd_valid, w_accept, w_last, w_unused;

    assign w_word   = PC[OW+1:2];
    assign w_idx    = PC[OW+IW+1:OW+2];
    assign w_tag    = PC[31:OW+IW+2];
    assign w_unused = ^PC[1:0];

    assign hit      = r_state == IDLE && w_rd_valid && w_rd_tag == w_tag;
    assign stall    = ~hit;
    assign instr    = hit ? w_rd_data : NOP_INSTR;
    assign mem_req  = r_state == REFILL;
    assign mem_addr = mem_req ? {r_base, r_cnt, 2'b00} : '0;
    assign w_accept = mem_req && mem_valid;
    assign w_last   = w_accept && &r_cnt;

    always_comb begin
        w_next = r_state;
        if (invalidate) w_next = IDLE;
        else if (r_state == IDLE && !hit) w_next = REFILL;
        else if (w_last) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // The line base tracks PC while idle, so it holds the missing line on the edge that enters REFILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_base <= '0;
        end else if (r_state == IDLE) begin
            r_cnt  <= '0;
            r_base <= PC[31:OW+2];
        end else if (w_accept) begin
            r_cnt  <= r_cnt + OW'(1);
        end
    end

    icache_line_store #(.SETS(SETS), .WORDS(WORDS_PER_LINE)) u_store (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_accept),
        .i_wr_idx    (r_base[IW-1:0]),
        .i_wr_word   (r_cnt),
        .i_wr_data   (mem_rdata),
        .i_set_tag   (w_last && !invalidate),
        .i_tag       (r_base[IW+TW-1:IW]),
        .i_clear_all (invalidate),
        .i_rd_idx    (w_idx),
        .i_rd_word   (w_word),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data)
    );
endmodule
